float_unit_arbiter: RTL and testbench
=====================================

Name: float_unit_arbiter

Overview:
Shares one pipelined floating-point unit among NUM_REQ requesters. The unit has two operand channels (a, b) and one result channel, all valid/ready, in-order, with fixed latency (29 cycles for the sqrt core).
- Front end: round-robin arbitration of requester operand pairs into a registered issue stage.
- Tagging: each issued op's requester index is pushed into an in-order tag FIFO.
- Back end: each returning result is steered to the requester named by the head tag.

Parameters:
- SIZE, 32, operand/result width in bits.
- NUM_REQ, 4, number of requesters (≥2).
- MAX_OUTSTANDING, 32, tag FIFO depth; limits ops in flight. Must be ≥ unit latency + 1 for one op per cycle.
- TAG_W, $clog2(NUM_REQ), derived, not overridable.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- req_a_tdata  in  NUM_REQ*SIZE  operand a per requester; slice i = requester i
- req_b_tdata  in  NUM_REQ*SIZE  operand b per requester
- req_tvalid  in  NUM_REQ  requester i presents an operand pair
- req_tready  out  NUM_REQ  one-hot grant; request i accepted when req_tvalid[i] && req_tready[i]
- m_axis_a_tdata  out  SIZE  operand a to unit
- m_axis_a_tvalid  out  1
- m_axis_a_tready  in  1
- m_axis_b_tdata  out  SIZE  operand b to unit
- m_axis_b_tvalid  out  1
- m_axis_b_tready  in  1
- s_axis_result_tdata  in  SIZE  unit result
- s_axis_result_tvalid  in  1
- s_axis_result_tready  out  1
- rsp_tdata  out  SIZE  result, shared by all requesters
- rsp_tvalid  out  NUM_REQ  one-hot; bit = head tag
- rsp_tready  in  NUM_REQ
- outstanding  out  $clog2(MAX_OUTSTANDING+1)  tag FIFO occupancy
- err_orphan  out  1  sticky; result arrived with tag FIFO empty

Behaviour:
- Reset: reset aresetn, synchronous, active-low; clock aclk.
  - On reset: state IDLE; rr pointer 0; FIFO empty; outstanding 0; err_orphan 0.
  - On reset: all tvalid/tready outputs 0; data outputs don't-care.
  - Reset mid-operation discards in-flight tags and held operands. The unit shares the reset.
- FSM states:
  - IDLE: no held op.
  - ISSUE: operands held in registers; a_done/b_done flags track the two unit handshakes independently.
- Grant condition: state IDLE, or ISSUE completing this cycle (last outstanding a/b handshake occurs now); and FIFO count < MAX_OUTSTANDING; and some req_tvalid set.
- Grant selection: first valid requester at or after rr pointer, wrapping modulo NUM_REQ.
- On grant to requester i:
  - req_tready[i]=1 combinationally this cycle; req_tready depends only on registered state and req_tvalid.
  - Operands are latched and tag i is pushed.
  - rr pointer ← (i+1) mod NUM_REQ.
  - Next state ISSUE with a_done=b_done=0.
- m_axis_a_tvalid = ISSUE && !a_done; m_axis_b_tvalid = ISSUE && !b_done. Both are registered-state driven, never dependent on unit tready.
- ISSUE → IDLE when both handshakes are done and no new grant occurs. With a grant it stays in ISSUE with new data, giving 1 op/cycle sustained.
- Latency: request accepted in cycle N; m_axis valid from cycle N+1.
- Result path, FIFO non-empty, head tag h:
  - rsp_tvalid[h] = s_axis_result_tvalid; other bits 0.
  - rsp_tdata = s_axis_result_tdata.
  - s_axis_result_tready = rsp_tready[h].
  - Pop on result handshake.
- Result path, FIFO empty: s_axis_result_tready=1 (drain), rsp_tvalid=0. A result handshake sets err_orphan, which clears only on reset.
- FIFO boundaries:
  - Push and pop in the same cycle: count unchanged.
  - Full (count = MAX_OUTSTANDING): no grant even if a pop occurs that cycle.
  - Read/write pointers wrap modulo MAX_OUTSTANDING.
- Back-pressure from one requester's rsp_tready stalls all results (in-order unit). Issue continues until the FIFO is full.
- Tags are pushed at grant, not at unit acceptance. In-order pairing holds because ops enter the unit in grant order.

Decomposition:
- Package float_arb_pkg:
  - state enum {IDLE, ISSUE}.
  - Function rr_pick(valid, ptr) returning the one-hot grant.
- Sub-module tag_fifo (width TAG_W, depth MAX_OUTSTANDING).
  - Ports: push, push_data, pop, head, count, full, empty.
  - Synchronous reset.
- Top holds the FSM, operand registers, rr pointer and result steering.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with all req_tvalid=1.
  - Required: req_tready=0, m_axis_*_tvalid=0, rsp_tvalid=0, outstanding=0, err_orphan=0.
- Single op with the sqrt unit attached: req 2, a=0x40800000 (4.0).
  - Required: m_axis_a_tvalid next cycle.
  - Required: rsp_tvalid=4'b0100 with rsp_tdata=0x40000000 after unit latency.
  - Required: outstanding returns to 0.
- Round-robin: all four req_tvalid held high, unit always ready.
  - Required: grants 0,1,2,3,0,1 on consecutive cycles.
  - Required: results return in that tag order.
- Split operand readiness: m_axis_b_tready=0 for 5 cycles, a_tready=1.
  - Required: a accepted once, a_tvalid drops, b held stable.
  - Required: no new grant until the b handshake occurs.
- FIFO full: MAX_OUTSTANDING=4, rsp_tready=0, five requests.
  - Required: exactly 4 grants; 5th req_tready stays 0.
  - Required: after one rsp handshake, the 5th is granted the following cycle.
- Orphan: inject s_axis_result_tvalid with FIFO empty.
  - Required: tready=1, err_orphan=1, no rsp_tvalid.

Source files
------------

// File: rtl/float_arb_pkg.sv
// float_arb_pkg: shared state type and round-robin picker for float_unit_arbiter
package float_arb_pkg;
  localparam int MAX_REQ = 32;
  typedef enum logic {IDLE, ISSUE} state_t;
  // Iterates high-to-low so the nearest valid index after ptr wins.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int n);
    rr_pick = '0;
    for (int k = MAX_REQ - 1; k >= 0; k--) begin
      int idx;
      idx = (ptr + k >= n) ? ptr + k - n : ptr + k;
      if (k < n && valid[idx]) rr_pick = MAX_REQ'(1) << idx;
    end
  endfunction
endpackage

// File: rtl/tag_fifo.sv
// tag_fifo: in-order queue of requester tags for ops in flight in the unit
module tag_fifo #(
  parameter int W = 2,
  parameter int DEPTH = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  assign head = mem_q[rd_q];
  assign count = count_q;
  assign full = count_q == CW'(DEPTH);
  assign empty = count_q == '0;
  always_ff @(posedge aclk)
    if (push) mem_q[wr_q] <= push_data;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      wr_q <= '0;
      rd_q <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
      if (pop) rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
endmodule

// File: rtl/float_unit_arbiter.sv
// float_unit_arbiter: round-robin sharing of one in-order pipelined FP unit among NUM_REQ requesters
module float_unit_arbiter
  import float_arb_pkg::*;
#(
  parameter int SIZE = 32,
  parameter int NUM_REQ = 4,
  parameter int MAX_OUTSTANDING = 32,
  localparam int TAG_W = $clog2(NUM_REQ),
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NUM_REQ*SIZE-1:0] req_a_tdata,
  input  logic [NUM_REQ*SIZE-1:0] req_b_tdata,
  input  logic [NUM_REQ-1:0]      req_tvalid,
  output logic [NUM_REQ-1:0]      req_tready,
  output logic [SIZE-1:0]         m_axis_a_tdata,
  output logic                    m_axis_a_tvalid,
  input  logic                    m_axis_a_tready,
  output logic [SIZE-1:0]         m_axis_b_tdata,
  output logic                    m_axis_b_tvalid,
  input  logic                    m_axis_b_tready,
  input  logic [SIZE-1:0]         s_axis_result_tdata,
  input  logic                    s_axis_result_tvalid,
  output logic                    s_axis_result_tready,
  output logic [SIZE-1:0]         rsp_tdata,
  output logic [NUM_REQ-1:0]      rsp_tvalid,
  input  logic [NUM_REQ-1:0]      rsp_tready,
  output logic [CNT_W-1:0]        outstanding,
  output logic                    err_orphan
);
  state_t state_q;
  logic a_done_q, b_done_q, err_q;
  logic [SIZE-1:0] a_q, b_q;
  logic [TAG_W-1:0] rr_q, rr_d, gidx, head;
  logic [MAX_REQ-1:0] pick;
  logic a_hs, b_hs, issue_done, grant_ok, grant, full, empty, pop;
  assign m_axis_a_tvalid = state_q == ISSUE && !a_done_q;
  assign m_axis_b_tvalid = state_q == ISSUE && !b_done_q;
  assign m_axis_a_tdata = a_q;
  assign m_axis_b_tdata = b_q;
  assign a_hs = m_axis_a_tvalid && m_axis_a_tready;
  assign b_hs = m_axis_b_tvalid && m_axis_b_tready;
  assign issue_done = state_q == ISSUE && (a_done_q || a_hs) && (b_done_q || b_hs);
  // A full FIFO blocks the grant even when a pop lands in the same cycle.
  assign grant_ok = aresetn && (state_q == IDLE || issue_done) && !full;
  assign pick = rr_pick(MAX_REQ'(req_tvalid), int'(rr_q), NUM_REQ);
  assign req_tready = grant_ok ? pick[NUM_REQ-1:0] : '0;
  assign grant = grant_ok && |req_tvalid;
  always_comb begin
    gidx = '0;
    for (int i = 0; i < MAX_REQ; i++) if (pick[i]) gidx = TAG_W'(i);
  end
  assign rr_d = (gidx == TAG_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
  // With no tag outstanding, results are drained and flagged as orphans.
  assign s_axis_result_tready = aresetn && (empty || rsp_tready[head]);
  assign rsp_tvalid = (!empty && s_axis_result_tvalid) ? NUM_REQ'(1) << head : '0;
  assign rsp_tdata = s_axis_result_tdata;
  assign pop = !empty && s_axis_result_tvalid && s_axis_result_tready;
  assign err_orphan = err_q;
  always_ff @(posedge aclk)
    if (!aresetn) begin
      state_q <= IDLE;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      rr_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (grant) begin
        state_q <= ISSUE;
        a_done_q <= 1'b0;
        b_done_q <= 1'b0;
        a_q <= req_a_tdata[gidx*SIZE +: SIZE];
        b_q <= req_b_tdata[gidx*SIZE +: SIZE];
        rr_q <= rr_d;
      end else if (issue_done) begin
        state_q <= IDLE;
      end else begin
        a_done_q <= a_done_q || a_hs;
        b_done_q <= b_done_q || b_hs;
      end
      if (empty && s_axis_result_tvalid && s_axis_result_tready) err_q <= 1'b1;
    end
  tag_fifo #(.W(TAG_W), .DEPTH(MAX_OUTSTANDING)) u_tags (
    .aclk(aclk),
    .aresetn(aresetn),
    .push(grant),
    .push_data(gidx),
    .pop(pop),
    .head(head),
    .count(outstanding),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_float_unit_arbiter.sv
`timescale 1ns/1ps
// tb_float_unit_arbiter: scoreboard bench with a behavioural fixed-latency sqrt stand-in
module tb_float_unit_arbiter;
  localparam int LAT = 29;
  logic aclk = 1'b0, aresetn = 1'b0;
  always #5 aclk = ~aclk;
  logic [127:0] req_a = '0, req_b = '0;
  logic [3:0] req_tvalid = '0, req_tready, rsp_tvalid, rsp_tready = 4'hf;
  logic [31:0] ma_d, mb_d, rsp_tdata, res_d, ur_d = '0;
  logic ma_v, mb_v, ua_rdy = 1'b1, ub_rdy = 1'b1, res_v, res_rdy, err, ur_v = 1'b0, inj = 1'b0;
  logic [5:0] outst;
  assign res_v = ur_v | inj;
  assign res_d = inj ? 32'hdead_beef : ur_d;
  float_unit_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .req_a_tdata(req_a), .req_b_tdata(req_b), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .m_axis_a_tdata(ma_d), .m_axis_a_tvalid(ma_v), .m_axis_a_tready(ua_rdy),
    .m_axis_b_tdata(mb_d), .m_axis_b_tvalid(mb_v), .m_axis_b_tready(ub_rdy),
    .s_axis_result_tdata(res_d), .s_axis_result_tvalid(res_v), .s_axis_result_tready(res_rdy),
    .rsp_tdata(rsp_tdata), .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready),
    .outstanding(outst), .err_orphan(err)
  );
  logic [3:0] f_vld = '0, f_rdy, f_rsp_v, f_rsp_rdy = '0;
  logic [31:0] f_ma_d, f_mb_d, f_rsp_d;
  logic f_ma_v, f_mb_v, f_res_v = 1'b0, f_res_rdy, f_err;
  logic [2:0] f_out;
  float_unit_arbiter #(.MAX_OUTSTANDING(4)) dut_f (
    .aclk(aclk), .aresetn(aresetn),
    .req_a_tdata(req_a), .req_b_tdata(req_b), .req_tvalid(f_vld), .req_tready(f_rdy),
    .m_axis_a_tdata(f_ma_d), .m_axis_a_tvalid(f_ma_v), .m_axis_a_tready(1'b1),
    .m_axis_b_tdata(f_mb_d), .m_axis_b_tvalid(f_mb_v), .m_axis_b_tready(1'b1),
    .s_axis_result_tdata(32'h0), .s_axis_result_tvalid(f_res_v), .s_axis_result_tready(f_res_rdy),
    .rsp_tdata(f_rsp_d), .rsp_tvalid(f_rsp_v), .rsp_tready(f_rsp_rdy),
    .outstanding(f_out), .err_orphan(f_err)
  );
  int n_chk = 0, n_fail = 0, cyc = 0;
  logic [3:0] ev[$];
  logic [31:0] ed[$];
  logic [31:0] aq[$], bq[$], rq[$];
  int dq[$];
  logic [31:0] rr_res [4] = '{32'h3f80_0000, 32'h4080_0000, 32'h4040_0000, 32'h4100_0000};
  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask
  task automatic expect_rsp(input logic [3:0] v, input logic [31:0] d);
    ev.push_back(v);
    ed.push_back(d);
  endtask
  task automatic drain();
    for (int k = 0; k < 200 && ev.size() > 0; k++) @(negedge aclk);
    check("drain", 64'(ev.size()), 64'(0));
  endtask
  function automatic logic [31:0] fsqrt(input logic [31:0] a, input logic [31:0] b);
    case (a)
      32'h3f80_0000: fsqrt = 32'h3f80_0000;
      32'h4080_0000: fsqrt = 32'h4000_0000;
      32'h4110_0000: fsqrt = 32'h4040_0000;
      32'h4180_0000: fsqrt = 32'h4080_0000;
      32'h4280_0000: fsqrt = 32'h4100_0000;
      default:       fsqrt = a ^ b;
    endcase
  endfunction
  // Unit stand-in: pairs a/b in arrival order, presents the result LAT cycles later.
  always @(posedge aclk) begin
    cyc <= cyc + 1;
    if (!aresetn) begin
      aq.delete(); bq.delete(); rq.delete(); dq.delete();
      ur_v <= 1'b0;
    end else begin
      if (ur_v && res_rdy) begin
        void'(rq.pop_front());
        void'(dq.pop_front());
      end
      if (ma_v && ua_rdy) aq.push_back(ma_d);
      if (mb_v && ub_rdy) bq.push_back(mb_d);
      if (aq.size() > 0 && bq.size() > 0) begin
        rq.push_back(fsqrt(aq.pop_front(), bq.pop_front()));
        dq.push_back(cyc + LAT);
      end
      ur_v <= rq.size() > 0 && (dq[0] <= cyc + 1);
      ur_d <= rq.size() > 0 ? rq[0] : '0;
    end
  end
  always @(negedge aclk) begin
    #2;
    if (aresetn && (rsp_tvalid & rsp_tready) != 4'b0) begin
      if (ev.size() == 0) check("rsp_unexpected", 64'(rsp_tvalid), 64'(0));
      else begin
        check("rsp_dst", 64'(rsp_tvalid), 64'(ev.pop_front()));
        check("rsp_data", 64'(rsp_tdata), 64'(ed.pop_front()));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int n;
    req_a = {32'h4280_0000, 32'h4110_0000, 32'h4180_0000, 32'h3f80_0000};
    req_b = {32'h3, 32'h2, 32'h1, 32'h0};
    req_tvalid = 4'hf;
    repeat (3) @(negedge aclk);
    #1;
    check("rst_req_tready", 64'(req_tready), 64'(0));
    check("rst_a_tvalid", 64'(ma_v), 64'(0));
    check("rst_b_tvalid", 64'(mb_v), 64'(0));
    check("rst_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
    check("rst_outstanding", 64'(outst), 64'(0));
    check("rst_err_orphan", 64'(err), 64'(0));
    @(negedge aclk);
    aresetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge aclk);
      #1 check("rr_grant", 64'(req_tready), 64'(4'b0001 << (k % 4)));
      expect_rsp(4'b0001 << (k % 4), rr_res[k % 4]);
    end
    @(negedge aclk);
    req_tvalid = '0;
    drain();
    @(negedge aclk);
    req_a[64 +: 32] = 32'h4080_0000;
    req_tvalid = 4'b0100;
    #1 check("single_grant", 64'(req_tready), 64'(4'b0100));
    expect_rsp(4'b0100, 32'h4000_0000);
    @(negedge aclk);
    req_tvalid = '0;
    #1 check("single_a_tvalid", 64'(ma_v), 64'(1));
    check("single_a_tdata", 64'(ma_d), 64'(32'h4080_0000));
    check("single_outstanding", 64'(outst), 64'(1));
    drain();
    #1 check("single_outstanding_end", 64'(outst), 64'(0));
    @(negedge aclk);
    req_a[31:0] = 32'h4180_0000;
    req_b[31:0] = 32'h1234_5678;
    req_tvalid = 4'b0001;
    ub_rdy = 1'b0;
    #1 check("split_grant", 64'(req_tready), 64'(4'b0001));
    expect_rsp(4'b0001, 32'h4080_0000);
    for (int k = 1; k <= 5; k++) begin
      @(negedge aclk);
      #1 check("split_a_tvalid", 64'(ma_v), 64'(k == 1));
      check("split_b_tvalid", 64'(mb_v), 64'(1));
      check("split_b_tdata", 64'(mb_d), 64'(32'h1234_5678));
      check("split_no_grant", 64'(req_tready), 64'(0));
    end
    @(negedge aclk);
    ub_rdy = 1'b1;
    #1 check("split_regrant", 64'(req_tready), 64'(4'b0001));
    expect_rsp(4'b0001, 32'h4080_0000);
    @(negedge aclk);
    req_tvalid = '0;
    drain();
    check("orphan_err_before", 64'(err), 64'(0));
    inj = 1'b1;
    #1 check("orphan_tready", 64'(res_rdy), 64'(1));
    check("orphan_rsp_tvalid", 64'(rsp_tvalid), 64'(0));
    @(negedge aclk);
    inj = 1'b0;
    #1 check("orphan_err", 64'(err), 64'(1));
    check("orphan_outstanding", 64'(outst), 64'(0));
    @(negedge aclk);
    f_vld = 4'hf;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      #1 if (f_rdy != 4'b0) n++;
      @(negedge aclk);
    end
    check("full_grant_count", 64'(n), 64'(4));
    #1 check("full_no_grant", 64'(f_rdy), 64'(0));
    check("full_outstanding", 64'(f_out), 64'(4));
    f_res_v = 1'b1;
    f_rsp_rdy = 4'b0001;
    #1 check("full_pop_no_grant", 64'(f_rdy), 64'(0));
    check("full_rsp_tvalid", 64'(f_rsp_v), 64'(4'b0001));
    @(negedge aclk);
    f_res_v = 1'b0;
    f_rsp_rdy = '0;
    #1 check("full_regrant", 64'(f_rdy), 64'(4'b0001));
    check("full_outstanding_after_pop", 64'(f_out), 64'(3));
    @(negedge aclk);
    f_vld = '0;
    repeat (2) @(negedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
